// File: rtl/rv32_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : rv32_wb_arbiter_if
// Description : Bundle of the writeback-arbiter bus signals. It carries the
//               pipeline writeback, the MLU result handshake, the MLU issue
//               notification, the decode operand fields, and the stall,
//               register-file and debug outputs.
//               modport slave  : arbiter view (bus inputs in, results out)
//               modport master : environment view (drives the arbiter inputs)
// Revision    : 1.0 - initial release
// ============================================================================
interface rv32_wb_arbiter_if;
    // Pipeline writeback (cannot be backpressured)
    logic        pipe_wb_valid;
    logic [4:0]  pipe_wb_rd;
    logic [31:0] pipe_wb_data;
    // MLU result handshake
    logic        mlu_valid;
    logic        mlu_ready;
    logic [4:0]  mlu_rd;
    logic [31:0] mlu_data;
    // MLU dispatch notification
    logic        mlu_issue;
    logic [4:0]  mlu_issue_rd;
    // Decode operands
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [4:0]  dec_rd;
    logic        dec_use_rs1;
    logic        dec_use_rs2;
    logic        dec_write_rd;
    // Stalls
    logic        hazard_stall;
    logic        starve_stall;
    // Register-file write port
    logic        rf_write;
    logic [4:0]  rf_rw;
    logic [31:0] rf_d;
    // Debug
    logic [31:0] busy_mask;

    modport slave (
        input  pipe_wb_valid, pipe_wb_rd, pipe_wb_data,
        input  mlu_valid, mlu_rd, mlu_data,
        output mlu_ready,
        input  mlu_issue, mlu_issue_rd,
        input  dec_rs1, dec_rs2, dec_rd, dec_use_rs1, dec_use_rs2, dec_write_rd,
        output hazard_stall, starve_stall,
        output rf_write, rf_rw, rf_d,
        output busy_mask
    );

    modport master (
        output pipe_wb_valid, pipe_wb_rd, pipe_wb_data,
        output mlu_valid, mlu_rd, mlu_data,
        input  mlu_ready,
        output mlu_issue, mlu_issue_rd,
        output dec_rs1, dec_rs2, dec_rd, dec_use_rs1, dec_use_rs2, dec_write_rd,
        input  hazard_stall, starve_stall,
        input  rf_write, rf_rw, rf_d,
        input  busy_mask
    );
endinterface
`default_nettype wire

// File: rtl/rv32_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rv32_wb_arbiter
// Description : Shares the single register-file write port between the
//               fixed-latency pipeline writeback (always wins) and the
//               multi-cycle unit (valid/ready). A starvation counter asks the
//               pipeline for a one-cycle bubble so MLU results always drain.
//               A busy scoreboard of outstanding MLU destinations stalls
//               decode on RAW/WAW hazards.
// Ports       : clk   - clock, all state updates on posedge
//               reset - synchronous active-high reset
//               bus   - rv32_wb_arbiter_if.slave (writeback, MLU, decode,
//                       stall, register-file and debug signals)
// Parameters  : STARVE_LIMIT - consecutive blocked MLU cycles before
//                              starve_stall asserts (>= 1)
// Revision    : 1.0 - initial release
// ============================================================================
module rv32_wb_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  wire logic           clk,
    input  wire logic           reset,
    rv32_wb_arbiter_if.slave    bus
);

    localparam int                CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]  c_limit = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0]  c_one   = CNT_W'(1);

    // State
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [31:0]      busy_q,     busy_d;
    logic             rf_write_q, rf_write_d;
    logic [4:0]       rf_rw_q,    rf_rw_d;
    logic [31:0]      rf_d_q,     rf_d_d;

    // Combinational
    logic w_mlu_ready;
    logic w_accept;
    logic w_starve;
    logic w_hazard;

    // Ready depends only on reset and the pipeline, never on mlu_valid.
    assign w_mlu_ready = !reset && !bus.pipe_wb_valid;
    assign w_accept    = bus.mlu_valid && w_mlu_ready;
    assign w_starve    = !reset && (cnt_q == c_limit);

    // busy_q[0] is held at 0, so an x0 operand can never stall.
    assign w_hazard = !reset && (
                          (bus.dec_use_rs1  && busy_q[bus.dec_rs1]) ||
                          (bus.dec_use_rs2  && busy_q[bus.dec_rs2]) ||
                          (bus.dec_write_rd && busy_q[bus.dec_rd]));

    always_comb begin
        // Starvation counter: counts cycles an MLU result sits blocked.
        // Cleared once starve_stall has been raised, because the pipeline
        // guarantees a bubble in the following cycle.
        cnt_d = cnt_q + c_one;
        if (w_accept || !bus.mlu_valid || w_starve) begin
            cnt_d = '0;
        end

        // Scoreboard: clear is applied first so a same-cycle set wins.
        busy_d = busy_q;
        if (w_accept && (bus.mlu_rd != 5'd0)) begin
            busy_d[bus.mlu_rd] = 1'b0;
        end
        if (bus.mlu_issue && (bus.mlu_issue_rd != 5'd0)) begin
            busy_d[bus.mlu_issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;

        // Output stage: index/data hold when there is no winner.
        rf_write_d = 1'b0;
        rf_rw_d    = rf_rw_q;
        rf_d_d     = rf_d_q;
        if (bus.pipe_wb_valid) begin
            rf_write_d = (bus.pipe_wb_rd != 5'd0);
            rf_rw_d    = bus.pipe_wb_rd;
            rf_d_d     = bus.pipe_wb_data;
        end else if (w_accept) begin
            rf_write_d = (bus.mlu_rd != 5'd0);
            rf_rw_d    = bus.mlu_rd;
            rf_d_d     = bus.mlu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            busy_q     <= '0;
            rf_write_q <= 1'b0;
            rf_rw_q    <= 5'd0;
            rf_d_q     <= 32'd0;
        end else begin
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            rf_write_q <= rf_write_d;
            rf_rw_q    <= rf_rw_d;
            rf_d_q     <= rf_d_d;
        end
    end

    assign bus.mlu_ready    = w_mlu_ready;
    assign bus.hazard_stall = w_hazard;
    assign bus.starve_stall = w_starve;
    assign bus.rf_write     = rf_write_q;
    assign bus.rf_rw        = rf_rw_q;
    assign bus.rf_d         = rf_d_q;
    assign bus.busy_mask    = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_rv32_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv32_wb_arbiter
// Description : Self-checking bench for rv32_wb_arbiter. Directed scenarios
//               plus a randomized run against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32_wb_arbiter;

    localparam int L = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rv32_wb_arbiter_if bus();

    rv32_wb_arbiter #(.STARVE_LIMIT(L)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state (random test)
    bit          m_busy [32];
    int          m_block;
    bit          m_wr;
    logic [4:0]  m_rw;
    logic [31:0] m_d;

    task automatic idle();
        bus.pipe_wb_valid = 1'b0; bus.pipe_wb_rd = 5'd0; bus.pipe_wb_data = 32'd0;
        bus.mlu_valid = 1'b0; bus.mlu_rd = 5'd0; bus.mlu_data = 32'd0;
        bus.mlu_issue = 1'b0; bus.mlu_issue_rd = 5'd0;
        bus.dec_rs1 = 5'd0; bus.dec_rs2 = 5'd0; bus.dec_rd = 5'd0;
        bus.dec_use_rs1 = 1'b0; bus.dec_use_rs2 = 1'b0; bus.dec_write_rd = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        tick();
        // During reset with mlu_valid high and pipe idle: ready must still be 0
        bus.mlu_valid = 1'b1;
        #1;
        total++; if (bus.mlu_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", bus.mlu_ready); end
        total++; if (bus.starve_stall !== 1'b0) begin bad++; $display("FAIL reset_starve got=%b exp=0", bus.starve_stall); end
        tick();
        total++; if (bus.rf_write !== 1'b0) begin bad++; $display("FAIL reset_rf_write got=%b exp=0", bus.rf_write); end
        total++; if (bus.rf_rw !== 5'd0) begin bad++; $display("FAIL reset_rf_rw got=%0d exp=0", bus.rf_rw); end
        total++; if (bus.rf_d !== 32'd0) begin bad++; $display("FAIL reset_rf_d got=%h exp=0", bus.rf_d); end
        total++; if (bus.busy_mask !== 32'd0) begin bad++; $display("FAIL reset_busy got=%h exp=0", bus.busy_mask); end
        reset = 1'b0;
        idle();
        tick();
    endtask

    task automatic test_pipe_only();
        bus.pipe_wb_valid = 1'b1; bus.pipe_wb_rd = 5'd5; bus.pipe_wb_data = 32'hDEADBEEF;
        tick();
        idle();
        total++; if (bus.rf_write !== 1'b1) begin bad++; $display("FAIL pipe_write got=%b exp=1", bus.rf_write); end
        total++; if (bus.rf_rw !== 5'd5) begin bad++; $display("FAIL pipe_rw got=%0d exp=5", bus.rf_rw); end
        total++; if (bus.rf_d !== 32'hDEADBEEF) begin bad++; $display("FAIL pipe_d got=%h exp=deadbeef", bus.rf_d); end
        tick();
        total++; if (bus.rf_write !== 1'b0) begin bad++; $display("FAIL idle_write got=%b exp=0", bus.rf_write); end
        total++; if (bus.rf_rw !== 5'd5 || bus.rf_d !== 32'hDEADBEEF) begin bad++; $display("FAIL idle_hold got=%0d/%h exp=5/deadbeef", bus.rf_rw, bus.rf_d); end
        bus.pipe_wb_valid = 1'b1; bus.pipe_wb_rd = 5'd0; bus.pipe_wb_data = 32'h12345678;
        tick();
        idle();
        total++; if (bus.rf_write !== 1'b0) begin bad++; $display("FAIL pipe_x0 got=%b exp=0", bus.rf_write); end
        tick();
    endtask

    task automatic test_collision();
        bus.pipe_wb_valid = 1'b1; bus.pipe_wb_rd = 5'd3; bus.pipe_wb_data = 32'h11;
        bus.mlu_valid = 1'b1; bus.mlu_rd = 5'd7; bus.mlu_data = 32'h22;
        #1;
        total++; if (bus.mlu_ready !== 1'b0) begin bad++; $display("FAIL coll_ready0 got=%b exp=0", bus.mlu_ready); end
        tick();
        bus.pipe_wb_valid = 1'b0;
        #1;
        total++; if (bus.mlu_ready !== 1'b1) begin bad++; $display("FAIL coll_ready1 got=%b exp=1", bus.mlu_ready); end
        total++; if (bus.rf_write !== 1'b1 || bus.rf_rw !== 5'd3 || bus.rf_d !== 32'h11) begin bad++; $display("FAIL coll_pipe got=%b/%0d/%h exp=1/3/11", bus.rf_write, bus.rf_rw, bus.rf_d); end
        tick();
        idle();
        total++; if (bus.rf_write !== 1'b1 || bus.rf_rw !== 5'd7 || bus.rf_d !== 32'h22) begin bad++; $display("FAIL coll_mlu got=%b/%0d/%h exp=1/7/22", bus.rf_write, bus.rf_rw, bus.rf_d); end
        tick();
    endtask

    task automatic test_starvation();
        // Two rounds: the second shows the counter restarted from 0 after
        // the first accept (starve again exactly L cycles later).
        for (int round = 0; round < 2; round++) begin
            logic [4:0] rd;
            rd = 5'd12 + 5'(round);
            for (int c = 0; c <= L; c++) begin
                bus.pipe_wb_valid = 1'b1; bus.pipe_wb_rd = 5'd1; bus.pipe_wb_data = 32'(c);
                bus.mlu_valid = 1'b1; bus.mlu_rd = rd; bus.mlu_data = 32'hCAFE0000 + 32'(rd);
                #1;
                total++;
                if (bus.starve_stall !== (c == L)) begin
                    bad++; $display("FAIL starve_r%0d_c%0d got=%b exp=%b", round, c, bus.starve_stall, (c == L));
                end
                tick();
            end
            // Bubble cycle: accept
            bus.pipe_wb_valid = 1'b0;
            #1;
            total++; if (bus.mlu_ready !== 1'b1 || bus.starve_stall !== 1'b0) begin bad++; $display("FAIL starve_bubble got=%b/%b exp=1/0", bus.mlu_ready, bus.starve_stall); end
            tick();
            total++; if (bus.rf_write !== 1'b1 || bus.rf_rw !== rd || bus.rf_d !== 32'hCAFE0000 + 32'(rd)) begin bad++; $display("FAIL starve_mlu_wr got=%b/%0d/%h exp=1/%0d", bus.rf_write, bus.rf_rw, bus.rf_d, rd); end
        end
        idle();
        tick();
    endtask

    task automatic test_scoreboard();
        bus.mlu_issue = 1'b1; bus.mlu_issue_rd = 5'd9;
        bus.dec_rs2 = 5'd9; bus.dec_use_rs2 = 1'b1;
        #1;
        total++; if (bus.hazard_stall !== 1'b0) begin bad++; $display("FAIL sb_issue_cycle got=%b exp=0", bus.hazard_stall); end
        tick();
        bus.mlu_issue = 1'b0; bus.mlu_issue_rd = 5'd0;
        #1;
        total++; if (bus.busy_mask !== 32'h200) begin bad++; $display("FAIL sb_busy got=%h exp=200", bus.busy_mask); end
        total++; if (bus.hazard_stall !== 1'b1) begin bad++; $display("FAIL sb_raw got=%b exp=1", bus.hazard_stall); end
        tick();
        bus.dec_use_rs2 = 1'b0; bus.dec_rs1 = 5'd9; bus.dec_rd = 5'd9; bus.dec_write_rd = 1'b0;
        #1;
        total++; if (bus.hazard_stall !== 1'b0) begin bad++; $display("FAIL sb_unused got=%b exp=0", bus.hazard_stall); end
        bus.dec_write_rd = 1'b1;
        #1;
        total++; if (bus.hazard_stall !== 1'b1) begin bad++; $display("FAIL sb_waw got=%b exp=1", bus.hazard_stall); end
        tick();
        bus.mlu_valid = 1'b1; bus.mlu_rd = 5'd9; bus.mlu_data = 32'h99;
        #1;
        total++; if (bus.hazard_stall !== 1'b1) begin bad++; $display("FAIL sb_nobypass got=%b exp=1", bus.hazard_stall); end
        tick();
        bus.mlu_valid = 1'b0;
        #1;
        total++; if (bus.hazard_stall !== 1'b0 || bus.busy_mask !== 32'd0) begin bad++; $display("FAIL sb_clear got=%b/%h exp=0/0", bus.hazard_stall, bus.busy_mask); end
        total++; if (bus.rf_write !== 1'b1 || bus.rf_rw !== 5'd9 || bus.rf_d !== 32'h99) begin bad++; $display("FAIL sb_mlu_wr got=%b/%0d/%h exp=1/9/99", bus.rf_write, bus.rf_rw, bus.rf_d); end
        idle();
        tick();
    endtask

    task automatic test_set_clear();
        bus.mlu_issue = 1'b1; bus.mlu_issue_rd = 5'd4;
        tick();
        bus.mlu_valid = 1'b1; bus.mlu_rd = 5'd4; bus.mlu_data = 32'h44;
        tick();
        idle();
        total++; if (bus.busy_mask !== 32'h10) begin bad++; $display("FAIL setclr_setwins got=%h exp=10", bus.busy_mask); end
        bus.mlu_issue = 1'b1; bus.mlu_issue_rd = 5'd0;
        tick();
        idle();
        total++; if (bus.busy_mask !== 32'h10) begin bad++; $display("FAIL setclr_x0 got=%h exp=10", bus.busy_mask); end
        bus.mlu_valid = 1'b1; bus.mlu_rd = 5'd4; bus.mlu_data = 32'h45;
        tick();
        idle();
        total++; if (bus.busy_mask !== 32'h0) begin bad++; $display("FAIL setclr_clear got=%h exp=0", bus.busy_mask); end
        tick();
    endtask

    task automatic test_reset_mid();
        bus.mlu_issue = 1'b1; bus.mlu_issue_rd = 5'd9;
        bus.pipe_wb_valid = 1'b1; bus.pipe_wb_rd = 5'd6; bus.pipe_wb_data = 32'h66;
        bus.mlu_valid = 1'b1; bus.mlu_rd = 5'd20; bus.mlu_data = 32'h2020;
        tick();
        bus.mlu_issue = 1'b0;
        tick();
        // busy=0x200, cnt=2, rf_write=1
        reset = 1'b1;
        bus.pipe_wb_valid = 1'b0;
        bus.dec_rs1 = 5'd9; bus.dec_use_rs1 = 1'b1;
        #1;
        total++; if (bus.rf_write !== 1'b1 || bus.busy_mask !== 32'h200) begin bad++; $display("FAIL rmid_pre got=%b/%h exp=1/200", bus.rf_write, bus.busy_mask); end
        total++; if (bus.mlu_ready !== 1'b0 || bus.hazard_stall !== 1'b0) begin bad++; $display("FAIL rmid_during got=%b/%b exp=0/0", bus.mlu_ready, bus.hazard_stall); end
        tick();
        reset = 1'b0;
        bus.mlu_valid = 1'b0;
        #1;
        total++; if (bus.busy_mask !== 32'd0 || bus.rf_write !== 1'b0 || bus.rf_rw !== 5'd0 || bus.rf_d !== 32'd0) begin bad++; $display("FAIL rmid_after got=%h/%b/%0d/%h exp=0/0/0/0", bus.busy_mask, bus.rf_write, bus.rf_rw, bus.rf_d); end
        total++; if (bus.starve_stall !== 1'b0 || bus.hazard_stall !== 1'b0) begin bad++; $display("FAIL rmid_stalls got=%b/%b exp=0/0", bus.starve_stall, bus.hazard_stall); end
        idle();
        tick();
    endtask

    task automatic test_random();
        bit          prev_starve;
        bit          exp_ready, exp_acc, exp_starve, exp_haz;
        logic [31:0] exp_mask;
        reset = 1'b1;
        idle();
        tick();
        reset = 1'b0;
        tick();
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_block = 0; m_wr = 1'b0; m_rw = 5'd0; m_d = 32'd0;
        prev_starve = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            // Pipeline honours the bubble contract; otherwise busy ~75%.
            bus.pipe_wb_valid = prev_starve ? 1'b0 : ($urandom_range(3) != 0);
            bus.pipe_wb_rd    = 5'($urandom_range(7));
            bus.pipe_wb_data  = $urandom;
            // A pending MLU result is held stable until taken.
            if (!bus.mlu_valid) begin
                bus.mlu_valid = ($urandom_range(9) < 7);
                bus.mlu_rd    = 5'($urandom_range(7));
                bus.mlu_data  = $urandom;
            end
            bus.mlu_issue    = ($urandom_range(2) == 0);
            bus.mlu_issue_rd = 5'($urandom_range(7));
            bus.dec_rs1 = 5'($urandom_range(7)); bus.dec_use_rs1  = $urandom_range(1) != 0;
            bus.dec_rs2 = 5'($urandom_range(7)); bus.dec_use_rs2  = $urandom_range(1) != 0;
            bus.dec_rd  = 5'($urandom_range(7)); bus.dec_write_rd = $urandom_range(1) != 0;
            #1;
            exp_ready  = !bus.pipe_wb_valid;
            exp_acc    = bus.mlu_valid && exp_ready;
            exp_starve = (m_block == L);
            exp_haz    = (bus.dec_use_rs1  && bus.dec_rs1 != 0 && m_busy[bus.dec_rs1]) ||
                         (bus.dec_use_rs2  && bus.dec_rs2 != 0 && m_busy[bus.dec_rs2]) ||
                         (bus.dec_write_rd && bus.dec_rd  != 0 && m_busy[bus.dec_rd]);
            total++; if (bus.mlu_ready !== exp_ready) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, bus.mlu_ready, exp_ready); end
            total++; if (bus.starve_stall !== exp_starve) begin bad++; $display("FAIL rnd_starve cyc=%0d got=%b exp=%b", cyc, bus.starve_stall, exp_starve); end
            total++; if (bus.hazard_stall !== exp_haz) begin bad++; $display("FAIL rnd_hazard cyc=%0d got=%b exp=%b", cyc, bus.hazard_stall, exp_haz); end
            // Model update for this edge
            if (bus.pipe_wb_valid) begin
                m_wr = (bus.pipe_wb_rd != 0); m_rw = bus.pipe_wb_rd; m_d = bus.pipe_wb_data;
            end else if (exp_acc) begin
                m_wr = (bus.mlu_rd != 0); m_rw = bus.mlu_rd; m_d = bus.mlu_data;
            end else begin
                m_wr = 1'b0;
            end
            if (exp_acc) m_busy[bus.mlu_rd] = 1'b0;
            if (bus.mlu_issue) m_busy[bus.mlu_issue_rd] = 1'b1;
            m_busy[0] = 1'b0;
            if (exp_acc || !bus.mlu_valid || exp_starve) m_block = 0;
            else m_block = m_block + 1;
            prev_starve = exp_starve;
            tick();
            if (exp_acc) bus.mlu_valid = 1'b0;
            exp_mask = '0;
            for (int i = 0; i < 32; i++) exp_mask[i] = m_busy[i];
            total++; if (bus.rf_write !== m_wr || bus.rf_rw !== m_rw || bus.rf_d !== m_d) begin bad++; $display("FAIL rnd_rf cyc=%0d got=%b/%0d/%h exp=%b/%0d/%h", cyc, bus.rf_write, bus.rf_rw, bus.rf_d, m_wr, m_rw, m_d); end
            total++; if (bus.busy_mask !== exp_mask) begin bad++; $display("FAIL rnd_busy cyc=%0d got=%h exp=%h", cyc, bus.busy_mask, exp_mask); end
        end
        idle();
        tick();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_pipe_only();
        test_collision();
        test_starvation();
        test_scoreboard();
        test_set_clear();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
